demux4_16b_reg: RTL
===================

// Module: demux4_16b_reg
// PURPOSE
//  Registered 1-to-4 demultiplexer: the distribution-side counterpart of the 4-to-1 register-file/ALU
//  source select. Steers one 16-bit producer stream to one of four consumer lanes chosen by control.
//  Each lane holds its word in an output register until that consumer takes it (valid/ready).
//  Per-lane wrapping word counters support debug and verification.
// PARAMETERS
//  WIDTH    16  data width of in_data and each out_data lane
//  CNT_W    8   width of each per-lane delivered-word counter
// PORTS
//  clock         in   1          rising-edge clock for all state
//  reset_n       in   1          asynchronous, active-low reset
//  in_data       in   WIDTH      word from the producer
//  in_valid      in   1          in_data and control are valid this cycle
//  control       in   2          destination lane: 0..3
//  in_ready      out  1          demux accepts the word this cycle
//  out_data0..3  out  WIDTH      lane holding registers
//  out_valid0..3 out  1          lane register holds an undelivered word
//  out_ready0..3 in   1          lane consumer takes the word this cycle
//  count0..3     out  CNT_W      words delivered on each lane (wrapping)
// BEHAVIOUR
//  Reset (reset_n=0, asynchronous): all out_valid=0, out_data=0, count=0. Outputs are held while reset is low.
//   A word held in a lane is discarded, not delivered.
//  Accept: acc = in_valid & in_ready. in_ready = ~out_valid[control] | out_ready[control].
//   This is a combinational path from control and out_ready to in_ready. in_ready depends only on the selected lane.
//  Lane k delivery: del_k = out_valid_k & out_ready_k. On del_k, count_k <= count_k+1, wrapping 2^CNT_W-1 -> 0.
//  Lane k register update, per rising edge:
//   acc & control==k : out_data_k <= in_data, out_valid_k <= 1. This covers an empty lane and a
//    simultaneous deliver+refill; the refill gives full throughput with no bubble.
//   else if del_k    : out_valid_k <= 0. out_data_k holds its last value.
//   else             : hold.
//  Latency: a word accepted at edge N is visible on out_data_k/out_valid_k after edge N, i.e. 1 cycle.
//  Ordering: the words on each lane keep their accept order. No ordering is defined across lanes.
//  Independence: any number of lanes may deliver in the same cycle. A stalled lane blocks only words
//   addressed to it. in_ready can drop only when the selected lane is full and not being drained.
//  Producer rule: in_data and control must stay stable while in_valid=1 & in_ready=0.
//   The producer may retarget only after the word is accepted.
//  out_data_k is stable while out_valid_k=1 & out_ready_k=0.
//  control with in_valid=0 is don't-care: no state change and no counter change.
//  No combinational path from in_data to any out_data. All lane outputs are registered.
// TESTING
//  1 Reset: drive reset_n=0 mid-stream with lane 2 full -> all out_valid=0, counts=0 immediately,
//    before the next clock edge. After release, in_ready=1.
//  2 Steering: send 0x1111,0x2222,0x3333,0x4444 with control=0,1,2,3 and all out_ready=0 ->
//    each lane holds its word. in_ready=1 for all four sends.
//  3 Backpressure: lane 1 full and out_ready1=0, send 0xBEEF to lane 1 -> in_ready=0, 0xBEEF held at input.
//    Next, with out_ready1=1 -> the old word is delivered and 0xBEEF is loaded in the same edge.
//    out_valid1 stays 1 and count1 increments.
//  4 Lane isolation: lane 3 stalled full, then send 0x0A0A to lane 0 -> in_ready=1 and lane 0 is loaded
//    next cycle. Lane 3 data and count are unchanged.
//  5 Throughput: 64 back-to-back words to lane 2 with out_ready2=1 -> one word per cycle,
//    in order, 1-cycle latency, count2=64.
//  6 Wrap: 256 deliveries on lane 0 (CNT_W=8) -> count0 returns to 0. Other counts are unchanged.

Source files
------------

// File: rtl/demux4_16b_reg.sv
// Registered 1-to-4 demultiplexer: one producer stream steered by control into four
// valid/ready lane registers, each with a wrapping delivered-word counter.
module demux4_16b_reg #(
    parameter int WIDTH = 16,
    parameter int CNT_W = 8
) (
    input  logic             clock,
    input  logic             reset_n,
    input  logic [WIDTH-1:0] in_data,
    input  logic             in_valid,
    input  logic [1:0]       control,
    output logic             in_ready,
    output logic [WIDTH-1:0] out_data0,
    output logic [WIDTH-1:0] out_data1,
    output logic [WIDTH-1:0] out_data2,
    output logic [WIDTH-1:0] out_data3,
    output logic             out_valid0,
    output logic             out_valid1,
    output logic             out_valid2,
    output logic             out_valid3,
    input  logic             out_ready0,
    input  logic             out_ready1,
    input  logic             out_ready2,
    input  logic             out_ready3,
    output logic [CNT_W-1:0] count0,
    output logic [CNT_W-1:0] count1,
    output logic [CNT_W-1:0] count2,
    output logic [CNT_W-1:0] count3
);

    function automatic logic [CNT_W-1:0] wrap_inc(input logic [CNT_W-1:0] c);
        return c + 1'b1;
    endfunction

    logic [WIDTH-1:0] data_p0 [4];
    logic [CNT_W-1:0] cnt_p0  [4];
    logic [3:0]       vld_p0;
    logic [3:0]       rdy;
    logic [3:0]       del;
    logic             acc;

    assign rdy      = {out_ready3, out_ready2, out_ready1, out_ready0};
    assign del      = vld_p0 & rdy;
    // Only the addressed lane can stall the producer; a draining lane accepts a refill.
    assign in_ready = ~vld_p0[control] | rdy[control];
    assign acc      = in_valid & in_ready;

    // Stage p0: lane holding registers and delivery counters
    for (genvar k = 0; k < 4; k++) begin : g_lane
        always_ff @(posedge clock or negedge reset_n) begin
            if (!reset_n) begin
                data_p0[k] <= '0;
                vld_p0[k]  <= 1'b0;
                cnt_p0[k]  <= '0;
            end else begin
                if (acc && control == 2'(k)) begin
                    data_p0[k] <= in_data;
                    vld_p0[k]  <= 1'b1;
                end else if (del[k]) begin
                    vld_p0[k]  <= 1'b0;
                end
                if (del[k]) begin
                    cnt_p0[k] <= wrap_inc(cnt_p0[k]);
                end
            end
        end
    end

    assign out_data0  = data_p0[0];
    assign out_data1  = data_p0[1];
    assign out_data2  = data_p0[2];
    assign out_data3  = data_p0[3];
    assign out_valid0 = vld_p0[0];
    assign out_valid1 = vld_p0[1];
    assign out_valid2 = vld_p0[2];
    assign out_valid3 = vld_p0[3];
    assign count0     = cnt_p0[0];
    assign count1     = cnt_p0[1];
    assign count2     = cnt_p0[2];
    assign count3     = cnt_p0[3];

endmodule
